if_fetch_queue: RTL and testbench

//  Instruction-fetch stage directly upstream of mem_ctrl. Owns the fetch PC and drives it to mem_ctrl.pc.

---
 rtl/if_fetch_queue_pkg.sv | 14 +
 rtl/if_fifo.sv | 59 +++++
 rtl/if_fetch_queue.sv | 89 ++++++++
 tb/tb_if_fetch_queue.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_queue_pkg.sv
// Shared fetch-stage constants: instruction width, PC step and default reset PC.
// Imported by the fetch queue top and its FIFO.
package if_fetch_queue_pkg;

    localparam int          INST_W       = 32;
    localparam int          PC_STEP      = 4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    // Occupancy counter width for a queue of the given depth (0..depth inclusive).
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/if_fifo.sv
// In-order fetch FIFO: DEPTH entries, synchronous clear, combinational head read.
// Latency: a push is visible at the head one cycle later; no write-to-read bypass.
// Backpressure: the caller must not push when full without popping, nor pop when empty.
import if_fetch_queue_pkg::*;

module if_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      push,
    input  logic [DATA_W-1:0]         push_dat,
    input  logic                      pop,
    output logic [DATA_W-1:0]         head_dat,
    output logic [cnt_w(DEPTH)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;

    // Storage needs no reset: it is only read while count is non-zero.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[tail] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_dat = mem[head];

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch stage: owns the fetch PC, queues completed fetches in order, serves decode via valid/ready.
// Latency: pc_done in cycle N gives id_valid_o in N+1 on an empty queue.
// Backpressure: full queue drops the fetch and holds pc_o so the memory refetches; rdy_in=0 freezes all.
import if_fetch_queue_pkg::*;

module if_fetch_queue #(
    parameter int                QDEPTH   = 4,
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy_in,
    input  logic                       pc_done_i,
    input  logic [INST_W-1:0]          inst_i,
    input  logic [ADDR_W-1:0]          pc_num_i,
    output logic [ADDR_W-1:0]          pc_o,
    input  logic                       br_flag_i,
    input  logic [ADDR_W-1:0]          br_target_i,
    input  logic                       id_ready_i,
    output logic                       id_valid_o,
    output logic [ADDR_W-1:0]          id_pc_o,
    output logic [INST_W-1:0]          id_inst_o,
    output logic [cnt_w(QDEPTH)-1:0]   q_count_o
);

    localparam int CNT_W  = cnt_w(QDEPTH);
    localparam int DATA_W = ADDR_W + INST_W;

    logic                flush_pend;
    logic [ADDR_W-1:0]   pend_target;
    logic                flush_now;
    logic [ADDR_W-1:0]   redirect_pc;
    logic                full;
    logic                pop;
    logic                push;
    logic                fifo_clear;
    logic                fifo_pop;
    logic [DATA_W-1:0]   head_dat;
    logic [CNT_W-1:0]    count;

    assign flush_now   = br_flag_i | flush_pend;
    // A fresh redirect in the applying cycle is newer than anything pending.
    assign redirect_pc = (br_flag_i ? br_target_i : pend_target) & ~ADDR_W'(3);

    assign full       = (count == CNT_W'(QDEPTH));
    assign id_valid_o = (count != '0);
    assign pop        = rdy_in & id_valid_o & id_ready_i;
    assign push       = rdy_in & pc_done_i & (pc_num_i == pc_o) & ~flush_now & (~full | pop);
    assign fifo_clear = rdy_in & flush_now;
    assign fifo_pop   = pop & ~flush_now;

    if_fifo #(
        .DEPTH  (QDEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clear    (fifo_clear),
        .push     (push),
        .push_dat ({pc_o, inst_i}),
        .pop      (fifo_pop),
        .head_dat (head_dat),
        .count    (count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_o        <= RESET_PC;
            flush_pend  <= 1'b0;
            pend_target <= '0;
        end else if (rdy_in) begin
            if (flush_now) begin
                pc_o       <= redirect_pc;
                flush_pend <= 1'b0;
            end else if (push) begin
                pc_o <= pc_o + ADDR_W'(PC_STEP);
            end
        end else if (br_flag_i) begin
            flush_pend  <= 1'b1;
            pend_target <= br_target_i;
        end
    end

    assign id_pc_o   = id_valid_o ? head_dat[DATA_W-1:INST_W] : '0;
    assign id_inst_o = id_valid_o ? head_dat[INST_W-1:0]      : '0;
    assign q_count_o = count;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: driver pushes expected {pc,inst} into a scoreboard,
// a negedge monitor pops and compares every decode handshake.
module tb_if_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy_in;
    logic        pc_done_i;
    logic [31:0] inst_i;
    logic [31:0] pc_num_i;
    logic [31:0] pc_o;
    logic        br_flag_i;
    logic [31:0] br_target_i;
    logic        id_ready_i;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic [2:0]  q_count_o;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_e;

    if_fetch_queue dut (
        .clk         (clk),
        .rst         (rst),
        .rdy_in      (rdy_in),
        .pc_done_i   (pc_done_i),
        .inst_i      (inst_i),
        .pc_num_i    (pc_num_i),
        .pc_o        (pc_o),
        .br_flag_i   (br_flag_i),
        .br_target_i (br_target_i),
        .id_ready_i  (id_ready_i),
        .id_valid_o  (id_valid_o),
        .id_pc_o     (id_pc_o),
        .id_inst_o   (id_inst_o),
        .q_count_o   (q_count_o)
    );

    always #5 clk = ~clk;

    // Monitor: every accepted head entry must match the oldest expected fetch.
    always @(negedge clk) begin
        if (rst && rdy_in && id_valid_o && id_ready_i && !br_flag_i) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected got pc=%h inst=%h want=none", id_pc_o, id_inst_o);
            end else begin
                mon_e = exp_q.pop_front();
                if ({id_pc_o, id_inst_o} !== mon_e) begin
                    bad++;
                    $display("FAIL pop_data got pc=%h inst=%h want pc=%h inst=%h",
                             id_pc_o, id_inst_o, mon_e[63:32], mon_e[31:0]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pcn, input logic [31:0] ins, input bit acc);
        pc_done_i = 1'b1;
        pc_num_i  = pcn;
        inst_i    = ins;
        if (acc) exp_q.push_back({pcn, ins});
        step();
        pc_done_i = 1'b0;
    endtask

    task automatic state(input string nm, input logic [31:0] pc, input int cnt);
        chk({nm, "_pc"}, pc_o, pc);
        chk({nm, "_cnt"}, {29'd0, q_count_o}, cnt[31:0]);
        chk({nm, "_vld"}, {31'd0, id_valid_o}, (cnt != 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        rst = 1'b0; rdy_in = 1'b1; pc_done_i = 1'b0; inst_i = '0; pc_num_i = '0;
        br_flag_i = 1'b0; br_target_i = '0; id_ready_i = 1'b0;
        repeat (2) step();
        state("reset", 32'h0, 0);
        chk("reset_id_pc", id_pc_o, 32'h0);
        chk("reset_id_inst", id_inst_o, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // 1: three fetches, first one visible the very next cycle
        fetch(32'h0, 32'hA000_0000, 1);
        state("t1_first", 32'h4, 1);
        chk("t1_head_pc", id_pc_o, 32'h0);
        chk("t1_head_inst", id_inst_o, 32'hA000_0000);
        fetch(32'h4, 32'hA000_0004, 1);
        fetch(32'h8, 32'hA000_0008, 1);
        state("t1", 32'hC, 3);

        // 2: fill, then a fifth completion is dropped and the PC holds
        fetch(32'hC, 32'hA000_000C, 1);
        state("t2_full", 32'h10, 4);
        fetch(32'h10, 32'hB000_0010, 0);
        state("t2_drop", 32'h10, 4);

        // 3: full queue, push and pop together
        id_ready_i = 1'b1;
        fetch(32'h10, 32'hB000_0010, 1);
        state("t3", 32'h14, 4);
        chk("t3_head_pc", id_pc_o, 32'h4);
        repeat (4) step();
        id_ready_i = 1'b0;
        state("t3_drained", 32'h14, 0);

        // 4: redirect with a completing fetch in the same cycle
        fetch(32'h14, 32'hC000_0014, 1);
        fetch(32'h18, 32'hC000_0018, 1);
        state("t4_pre", 32'h1C, 2);
        exp_q.delete();
        br_flag_i = 1'b1; br_target_i = 32'h103;
        fetch(32'h1C, 32'hC000_001C, 0);
        br_flag_i = 1'b0;
        state("t4", 32'h100, 0);

        // 5: stale completion ignored, redirected fetch accepted
        fetch(32'h1C, 32'hD000_001C, 0);
        state("t5_stale", 32'h100, 0);
        fetch(32'h100, 32'hE000_0100, 1);
        state("t5_new", 32'h104, 1);
        id_ready_i = 1'b1;
        step();
        id_ready_i = 1'b0;
        fetch(32'h104, 32'hF000_0104, 1);

        // 6: redirects while frozen, newest target wins on release
        rdy_in = 1'b0;
        br_flag_i = 1'b1; br_target_i = 32'h40;
        step();
        br_target_i = 32'h80;
        step();
        br_flag_i = 1'b0;
        fetch(32'h108, 32'hF000_0108, 0);
        state("t6_frozen", 32'h108, 1);
        exp_q.delete();
        rdy_in = 1'b1;
        step();
        state("t6_flush", 32'h80, 0);
        fetch(32'h80, 32'h6000_0080, 1);
        state("t6_after", 32'h84, 1);
        id_ready_i = 1'b1;
        step();
        id_ready_i = 1'b0;

        // 7: PC wrap, then asynchronous reset mid-fill
        br_flag_i = 1'b1; br_target_i = 32'hFFFF_FFFE;
        step();
        br_flag_i = 1'b0;
        state("t7_redir", 32'hFFFF_FFFC, 0);
        fetch(32'hFFFF_FFFC, 32'h7000_FFFC, 1);
        state("t7_wrap", 32'h0, 1);
        fetch(32'h0, 32'h7000_0000, 1);
        exp_q.delete();
        pc_done_i = 1'b1; pc_num_i = 32'h4; inst_i = 32'h7000_0004;
        #2 rst = 1'b0;
        #1;
        state("t7_async", 32'h0, 0);
        chk("t7_id_pc", id_pc_o, 32'h0);
        step();
        pc_done_i = 1'b0;
        state("t7_held", 32'h0, 0);
        @(negedge clk);
        rst = 1'b1;
        step();
        state("t7_release", 32'h0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
